// File: rtl/shared_mult_sched_pkg.sv
// Shared definitions for the shared shift-add multiplier scheduler.
package mult_sched_pkg;

  localparam int unsigned A_W_DEF = 16;
  localparam int unsigned B_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shared_mult_sched_step.sv
// One combinational shift-add multiply step: conditional accumulate, shift operands.
module mult_step #(
  parameter int unsigned A_W = 16,
  parameter int unsigned B_W = 8
) (
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  input  logic [A_W-1:0] acc_i,
  output logic [A_W-1:0] a_o,
  output logic [B_W-1:0] b_o,
  output logic [A_W-1:0] acc_o
);

  // Add the multiplicand when the current multiplier LSB is set; wraps modulo 2^A_W.
  always_comb begin
    a_o   = a_i << 1;
    b_o   = b_i >> 1;
    acc_o = acc_i + (b_i[0] ? a_i : '0);
  end

endmodule

// File: rtl/shared_mult_sched.sv
// Round-robin scheduler sharing one iterative 16x8 shift-add multiplier among N_REQ requesters.
module shared_mult_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned A_W   = A_W_DEF,
  parameter int unsigned B_W   = B_W_DEF,
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [A_W-1:0]     res_data,
  output logic [ID_W-1:0]    res_id,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(B_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(B_W - 1);

  state_t           state_q, state_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [A_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic             res_valid_q, res_valid_d;

  logic             found;
  logic [ID_W-1:0]  win;
  logic [A_W-1:0]   step_a, step_acc;
  logic [B_W-1:0]   step_b;

  mult_step #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_step (
    .a_i   (a_q),
    .b_i   (b_q),
    .acc_i (acc_q),
    .a_o   (step_a),
    .b_o   (step_b),
    .acc_o (step_acc)
  );

  // Round-robin pick: first valid requester searching upward from rr_q with wrap.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // Grant is offered only while idle; no dependence on res_ready.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found) begin
      req_ready[win] = 1'b1;
    end
  end

  // Next-state and datapath update: accept, B_W fixed steps, then hold result until taken.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          a_d     = req_a[32'(win)*A_W +: A_W];
          b_d     = req_b[32'(win)*B_W +: B_W];
          acc_d   = '0;
          cnt_d   = '0;
          id_d    = win;
          rr_d    = ID_W'((32'(win) + 1) % N_REQ);
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = step_a;
        b_d   = step_b;
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // res_valid gets its own flop so it cannot glitch on multi-bit state changes.
    res_valid_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      rr_q        <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      rr_q        <= rr_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = acc_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shared_mult_sched.sv
// Self-checking bench for shared_mult_sched: transaction-level model plus directed literals.
module tb_shared_mult_sched;

  localparam int A_W  = 16;
  localparam int B_W  = 8;
  localparam int N    = 2;
  localparam int ID_W = 1;

  logic                clk;
  logic                rst_n;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N*A_W-1:0]    req_a;
  logic [N*B_W-1:0]    req_b;
  logic                res_valid;
  logic                res_ready;
  logic [A_W-1:0]      res_data;
  logic [ID_W-1:0]     res_id;
  logic                busy;

  int n_cmp = 0;
  int n_bad = 0;

  shared_mult_sched #(
    .A_W   (A_W),
    .B_W   (B_W),
    .N_REQ (N),
    .ID_W  (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_left counts multiply cycles still to go; m_done means a result is on offer.
  int             m_left;
  bit             m_done;
  int             m_rr;
  int             m_id;
  logic [A_W-1:0] m_prod;
  int             m_win;

  function automatic int pick(input int rr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  always_comb m_win = pick(m_rr, req_valid);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_rr   <= 0;
      m_id   <= 0;
      m_prod <= '0;
    end else if (!m_done && m_left == 0) begin
      if (m_win >= 0) begin
        m_prod <= A_W'(32'(req_a[m_win*A_W +: A_W]) * 32'(req_b[m_win*B_W +: B_W]));
        m_id   <= m_win;
        m_rr   <= (m_win + 1) % N;
        m_left <= B_W;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (res_ready) begin
      m_done <= 1'b0;
    end
  end

  // Results actually delivered by the DUT, for the directed literal checks.
  logic [ID_W+A_W-1:0] got_q[$];

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    bit m_busy;
    m_busy  = (m_left > 0) || m_done;
    exp_rdy = '0;
    if (!m_busy && m_win >= 0) exp_rdy[m_win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_busy));
    if (m_done) begin
      chk("res_data", 32'(res_data), 32'(m_prod));
      chk("res_id", 32'(res_id), 32'(m_id));
    end
    if (!rst_n) begin
      chk("rst_res_data", 32'(res_data), 32'h0);
      chk("rst_res_id", 32'(res_id), 32'h0);
    end
    if (rst_n && res_valid && res_ready) got_q.push_back({res_id, res_data});
  end

  // ---------------- stimulus helpers ----------------
  task automatic req(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        @(posedge clk);
        #2;
        req_valid[i] = 1'b0;
        ok = 1'b1;
      end
    end
    if (!ok) chk($sformatf("grant%0d_timeout", i), 32'h0, 32'h1);
  endtask

  task automatic pop_res(input string nm, input int exp_id, input logic [A_W-1:0] exp_d);
    logic [ID_W+A_W-1:0] r;
    int n;
    n = 0;
    while (got_q.size() == 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (got_q.size() == 0) begin
      chk({nm, "_timeout"}, 32'h0, 32'h1);
    end else begin
      r = got_q.pop_front();
      chk({nm, "_data"}, 32'(r[A_W-1:0]), 32'(exp_d));
      chk({nm, "_id"}, 32'(r[ID_W+A_W-1:A_W]), 32'(exp_id));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_res_valid", 32'(res_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single request with latency measurement.
    req(0, 16'h0123, 8'h05);
    wait_grant(0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (res_valid) break;
    end
    chk("latency", 32'(lat), 32'd8);
    pop_res("single", 0, 16'h05AF);
    repeat (2) @(posedge clk);
    #2;
    chk("back_idle_busy", 32'(busy), 32'h0);

    // Overflow truncation and zero operand.
    req(0, 16'h1234, 8'hFF);
    wait_grant(0);
    pop_res("ovf", 0, 16'h21CC);
    req(1, 16'hFFFF, 8'h00);
    wait_grant(1);
    pop_res("zero", 1, 16'h0000);

    // Simultaneous requests after reset, twice: id0 then id1 each round.
    @(posedge clk);
    #2;
    do_reset();
    for (int rnd = 0; rnd < 2; rnd++) begin
      req(0, 16'h0002, 8'h03);
      req(1, 16'h0010, 8'h04);
      wait_grant(0);
      wait_grant(1);
      pop_res("simul_first", 0, 16'h0006);
      pop_res("simul_second", 1, 16'h0040);
    end
    repeat (12) @(posedge clk);
    #2;

    // Backpressure: result held 5 cycles while another request waits.
    res_ready = 1'b0;
    req(0, 16'h0007, 8'h03);
    wait_grant(0);
    req(1, 16'h0002, 8'h05);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(res_valid), 32'h1);
      chk("bp_data", 32'(res_data), 32'h0015);
      chk("bp_id", 32'(res_id), 32'h0);
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_busy", 32'(busy), 32'h1);
    end
    chk("bp_no_transfer", 32'(got_q.size()), 32'h0);
    @(posedge clk);
    #2;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_one_transfer", 32'(got_q.size()), 32'h1);
    pop_res("bp", 0, 16'h0015);
    wait_grant(1);
    pop_res("bp_next", 1, 16'h000A);
    repeat (12) @(posedge clk);
    #2;

    // Reset during RUN: result discarded, arbitration restarts at id0.
    req(0, 16'h0123, 8'h05);
    wait_grant(0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 32'h0);
    chk("mid_rst_data", 32'(res_data), 32'h0);
    chk("mid_rst_id", 32'(res_id), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    chk("mid_rst_no_result", 32'(got_q.size()), 32'h0);
    req(0, 16'h0003, 8'h04);
    req(1, 16'h0005, 8'h06);
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    wait_grant(0);
    wait_grant(1);
    pop_res("post_rst_0", 0, 16'h000C);
    pop_res("post_rst_1", 1, 16'h001E);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shared_mult_sched.md
# shared_mult_sched

Iterative shift-add multiplier scheduler that shares one 16x8 unsigned multiply datapath among N_REQ requesters in the FFT audio path, for example the twiddle-product sources of the butterfly stages. It arbitrates pending requests round-robin, latches the winner's operands, runs B_W shift-add steps, and returns a truncated product tagged with the requester id. A valid/ready handshake applies on both the request and result sides.

## Interface
- A_W, 16, multiplicand width and result width
- B_W, 8, multiplier width; equals the number of RUN steps
- N_REQ, 2, number of requesters (at least 2)
- ID_W, $clog2(N_REQ), requester id width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester request pending
- req_ready  out  N_REQ  one-hot grant; handshake completes when valid & ready
- req_a  in  N_REQ*A_W  packed multiplicands; requester i occupies [i*A_W +: A_W]
- req_b  in  N_REQ*B_W  packed multipliers; requester i occupies [i*B_W +: B_W]
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  A_W  product, truncated to A_W bits
- res_id  out  ID_W  index of the requester that owns res_data
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - If any req_valid is high, req_ready is asserted combinationally for exactly one requester, the round-robin winner.
  - The winner is the first valid requester searching upward (wrapping) from rr_ptr.
  - On the clock edge: latch a_reg = req_a[winner], b_reg = req_b[winner], acc = 0, cnt = 0, id_reg = winner, rr_ptr = winner+1 mod N_REQ. Go to RUN.
  - With no valid request, remain in IDLE and hold req_ready = 0.
- RUN, one step per cycle:
  - If b_reg[0], then acc <= acc + a_reg, modulo 2^A_W.
  - a_reg <= a_reg << 1 (zero fill, drop MSB).
  - b_reg <= b_reg >> 1 (zero fill).
  - cnt <= cnt + 1.
  - On the step where cnt == B_W-1, go to DONE.
  - No early exit when b_reg becomes 0; latency is fixed.
- DONE
  - res_valid = 1; res_data = acc; res_id = id_reg.
  - All three outputs hold stable until res_valid & res_ready, then go to IDLE.
- req_ready is 0 in RUN and DONE. Requesters must hold req_valid and their operands until granted. Deasserting req_valid before the grant withdraws the request, and that requester is not served.
- Arithmetic is unsigned. Overflow bits above A_W-1 are discarded. A zero operand gives 0.
- Reset mid-operation: the FSM returns to IDLE and acc, a_reg, b_reg, cnt, id_reg and rr_ptr go to 0. The in-flight result is lost and no res_valid is produced.
- Reset values of outputs: req_ready = 0, res_valid = 0, res_data = 0, res_id = 0, busy = 0.

## Timing
- Accept edge E0 (IDLE to RUN). RUN occupies edges E1..E_B_W. res_valid rises after edge E_B_W, i.e. B_W cycles after accept (8 at defaults).
- If res_ready is already high, DONE lasts one cycle. The next grant's combinational req_ready is asserted in the following IDLE cycle.
- Minimum spacing between accepts is B_W+2 cycles (10 at defaults).
- res_data, res_id and res_valid are registered and glitch-free. req_ready is combinational from req_valid and state, with no path from res_ready.
- When two requests arrive simultaneously, only the round-robin winner is granted. The other requester keeps valid high and is granted in the next IDLE, so a continuously requesting source waits at most N_REQ-1 service slots.

## Structure
- Package mult_sched_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default width constants A_W_DEF = 16 and B_W_DEF = 8.
- Sub-module mult_step: combinational single shift-add step. Inputs a, b, acc; outputs a<<1, b>>1, acc + (b[0] ? a : 0).
- The top level contains the FSM, the round-robin arbiter, the counter and the registers, and instantiates mult_step once.

## Test plan
- Single request: id0, a = 0x0123, b = 0x05, res_ready = 1. Expect res_valid 8 cycles after the grant, res_data = 0x05AF, res_id = 0, then back to IDLE.
- Overflow truncation: a = 0x1234, b = 0xFF. Expect res_data = 0x21CC (full product 0x1221CC); a = 0xFFFF, b = 0x00 gives 0x0000.
- Simultaneous requests after reset: id0 (0x0002 x 0x03) and id1 (0x0010 x 0x04) held valid. Expect id0 served first (0x0006), then id1 (0x0040). Repeating both requests again serves id0 then id1, alternating.
- Backpressure: hold res_ready = 0 for 5 cycles in DONE. Expect res_valid, res_data and res_id stable, req_ready = 0 and busy = 1 throughout; exactly one transfer once res_ready rises.
- Reset mid-RUN: assert rst_n = 0 at step 4. Expect all outputs to be 0 immediately (asynchronous), no res_valid after release, and the next request granted from id0.
